// File: rtl/spi_host_pkg.sv
// Shared types for the SPI host: FSM states, SPI mode encodings and a CS-width helper.
package spi_host_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // A single chip select still needs a 1-bit selector port.
  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_host_clkdiv.sv
// SCK half-period generator: down-counter reloaded on accept, one-cycle tick every cfg_div+1 cycles.
module spi_host_clkdiv #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      div_reg <= div;
      cnt_reg <= div;
    end else if (tick) begin
      cnt_reg <= div_reg;
    end else if (en) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/spi_host.sv
// SPI host with word width, SCK divider, CPOL/CPHA modes and chip-select hold.
// Optional LSB-first transfers are enabled by defining SPI_LSB_FIRST_EN (adds cfg_lsb).
module spi_host
  import spi_host_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DIV_W  = 8,
  parameter  int NCS    = 2,
  localparam int CS_W   = cs_width(NCS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic              cfg_lsb,
`endif
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
  input  logic [DATA_W-1:0] di,
  input  logic              wr,
  output logic [DATA_W-1:0] do_data,
  output logic              dsr,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NCS-1:0]    cs_n
);

  localparam int EC_W = $clog2(2 * DATA_W);

  state_t            state_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] rx_next;
  logic [EC_W-1:0]   edge_reg;
  logic              cpha_reg;
  logic              hold_reg;
  logic              lsb_reg;
  logic              miso_s_reg;
  logic              sample_reg;
  logic              lsb_in;
  logic              accept;
  logic              tick;
  logic              lead_edge;
  logic [NCS-1:0]    cs_dec;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = cfg_lsb;
`else
  assign lsb_in = 1'b0;
`endif

  assign accept    = wr && (state_reg == IDLE);
  assign lead_edge = ~edge_reg[0];

  generate
    for (genvar gi = 0; gi < NCS; gi++) begin : g_cs
      assign cs_dec[gi] = (cs_sel != CS_W'(gi));
    end
  endgenerate

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Sampling happens one cycle after the SCK edge, so the sync flop already holds the
  // level that was on miso when SCK moved; the final sample may land on the done edge.
  always_comb begin
    rx_next = rx_reg;
    if (sample_reg)
      rx_next = lsb_reg ? {miso_s_reg, rx_reg[DATA_W-1:1]} : {rx_reg[DATA_W-2:0], miso_s_reg};
  end

  spi_host_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .en      (state_reg != IDLE),
    .div     (cfg_div),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      tx_reg     <= '0;
      rx_reg     <= '0;
      edge_reg   <= '0;
      cpha_reg   <= 1'b0;
      hold_reg   <= 1'b0;
      lsb_reg    <= 1'b0;
      miso_s_reg <= 1'b0;
      sample_reg <= 1'b0;
      do_data    <= '0;
      dsr        <= 1'b0;
      busy       <= 1'b0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= '1;
    end else begin
      miso_s_reg <= miso;
      sample_reg <= 1'b0;
      rx_reg     <= rx_next;
      case (state_reg)
        IDLE: begin
          if (wr) begin
            cpha_reg  <= cfg_cpha;
            hold_reg  <= cs_hold;
            lsb_reg   <= lsb_in;
            dsr       <= 1'b0;
            busy      <= 1'b1;
            sck       <= cfg_cpol;
            cs_n      <= cs_dec;
            edge_reg  <= '0;
            rx_reg    <= '0;
            state_reg <= SETUP;
            if (!cfg_cpha) begin
              mosi   <= first_bit(di, lsb_in);
              tx_reg <= shift_out(di, lsb_in);
            end else begin
              tx_reg <= di;
            end
          end
        end
        SETUP: begin
          if (tick) state_reg <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sck      <= ~sck;
            edge_reg <= edge_reg + 1'b1;
            if (lead_edge ^ cpha_reg) begin
              sample_reg <= 1'b1;
            end else begin
              mosi   <= first_bit(tx_reg, lsb_reg);
              tx_reg <= shift_out(tx_reg, lsb_reg);
            end
            if (edge_reg == EC_W'(2 * DATA_W - 1)) state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            do_data   <= rx_next;
            dsr       <= 1'b1;
            busy      <= 1'b0;
            mosi      <= 1'b0;
            state_reg <= IDLE;
            if (!hold_reg) cs_n <= '1;
          end
        end
      endcase
    end
  end

endmodule
